t_clkq_setup_reader: RTL

//  Controller/reader at the far end of the t_clkq+t_setup measurement counter. On request it pulses the

---
 rtl/t_clkq_setup_reader_pkg.sv | 23 ++
 rtl/t_clkq_setup_reader_if.sv | 33 +++
 rtl/t_clkq_delta_stats.sv | 70 +++++++
 rtl/t_clkq_setup_reader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/t_clkq_setup_reader_pkg.sv
// rtl/t_clkq_setup_reader_pkg.sv - shared types and width helpers for the t_clkq+t_setup reader
package t_clkq_reader_pkg;

  // Controller states; WAIT spans the measurement window itself
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    SNAP = 3'd3,
    DONE = 3'd4
  } state_t;

  // Sum of n deltas of cnt_w bits cannot overflow this width
  function automatic int acc_width(input int cnt_w, input int n);
    return cnt_w + $clog2(n + 1);
  endfunction

  // Sample counter must be able to hold the value n
  function automatic int samp_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/t_clkq_setup_reader_if.sv
// rtl/t_clkq_setup_reader_if.sv - request/result handshake bundle between host and reader
interface t_clkq_setup_reader_if
  import t_clkq_reader_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int WIN_WIDTH   = 9,
  parameter int NUM_SAMPLES = 4
);
  localparam int ACC_WIDTH = acc_width(CNT_WIDTH, NUM_SAMPLES);

  logic                 req_valid;
  logic                 req_ready;
  logic [WIN_WIDTH-1:0] window_len;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_sum;
  logic [CNT_WIDTH-1:0] res_min;
  logic [CNT_WIDTH-1:0] res_max;
  logic                 res_err;

  // Host side: issues requests, consumes results
  modport master (
    output req_valid, window_len, res_ready,
    input  req_ready, res_valid, res_sum, res_min, res_max, res_err
  );

  // Reader side: accepts requests, produces results
  modport slave (
    input  req_valid, window_len, res_ready,
    output req_ready, res_valid, res_sum, res_min, res_max, res_err
  );

endinterface

// File: rtl/t_clkq_delta_stats.sv
// rtl/t_clkq_delta_stats.sv - window snapshot registers and running sum/min/max of deltas
module t_clkq_delta_stats #(
  parameter int CNT_WIDTH = 8,
  parameter int ACC_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 cap0,
  input  logic                 cap1,
  input  logic                 upd,
  input  logic [CNT_WIDTH-1:0] cnt_in,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [CNT_WIDTH-1:0] min_val,
  output logic [CNT_WIDTH-1:0] max_val
);

  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] delta;

  // Modular subtract: a counter wrap inside the window still yields the true distance
  assign delta = cnt1_q - cnt0_q;

  // Next-value logic for snapshots and statistics
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    sum_d  = sum_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clr) begin
      sum_d = '0;
      min_d = '1;
      max_d = '0;
    end
    if (cap0) cnt0_d = cnt_in;
    if (cap1) cnt1_d = cnt_in;
    if (upd) begin
      sum_d = sum_q + ACC_WIDTH'(delta);
      if (delta < min_q) min_d = delta;
      if (delta > max_q) max_d = delta;
    end
  end

  // Statistic registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      sum_q  <= '0;
      min_q  <= '0;
      max_q  <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      sum_q  <= sum_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign sum     = sum_q;
  assign min_val = min_q;
  assign max_val = max_q;

endmodule

// File: rtl/t_clkq_setup_reader.sv
// rtl/t_clkq_setup_reader.sv - sequences measurement windows and reports delta statistics
module t_clkq_setup_reader
  import t_clkq_reader_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int WIN_WIDTH   = 9,
  parameter int NUM_SAMPLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  t_clkq_setup_reader_if.slave  bus,
  output logic                  meas_start,
  input  logic [CNT_WIDTH-1:0]  meas_cnt,
  output logic                  busy
);

  localparam int ACC_WIDTH = acc_width(CNT_WIDTH, NUM_SAMPLES);
  localparam int SW        = samp_width(NUM_SAMPLES);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(NUM_SAMPLES - 1);
  // A window longer than the counter range would alias onto a shorter delta
  localparam int unsigned MAX_W = (2 ** CNT_WIDTH) - 1;

  state_t               state_q, state_d;
  logic [WIN_WIDTH-1:0] win_q, win_d;
  logic [WIN_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic                 err_q, err_d;

  logic                 win_bad;
  logic                 st_clr, st_cap0, st_cap1, st_upd;
  logic [ACC_WIDTH-1:0] stat_sum;
  logic [CNT_WIDTH-1:0] stat_min, stat_max;

  assign win_bad = (bus.window_len == '0) || (32'(bus.window_len) > MAX_W);

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      wcnt_q  <= '0;
      samp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wcnt_q  <= wcnt_d;
      samp_q  <= samp_d;
      err_q   <= err_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = win_bad ? DONE : ARM;
      ARM:  state_d = WAIT;
      WAIT: if (wcnt_q == '0) state_d = SNAP;
      SNAP: state_d = (samp_q == LAST_SAMPLE) ? DONE : ARM;
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window counter, sample counter and statistics strobes
  always_comb begin
    win_d   = win_q;
    wcnt_d  = wcnt_q;
    samp_d  = samp_q;
    err_d   = err_q;
    st_clr  = 1'b0;
    st_cap0 = 1'b0;
    st_cap1 = 1'b0;
    st_upd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          win_d  = bus.window_len;
          err_d  = win_bad;
          samp_d = '0;
          st_clr = 1'b1;
        end
      end
      ARM: begin
        wcnt_d  = win_q - WIN_WIDTH'(1);
        st_cap0 = 1'b1;
      end
      WAIT: begin
        if (wcnt_q == '0) st_cap1 = 1'b1;
        else              wcnt_d  = wcnt_q - WIN_WIDTH'(1);
      end
      SNAP: begin
        st_upd = 1'b1;
        samp_d = samp_q + SW'(1);
      end
      default: ;
    endcase
  end

  // Handshake and result outputs; a rejected request reports zeros
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.res_valid = (state_q == DONE);
    meas_start    = (state_q == ARM);
    busy          = (state_q != IDLE);
    bus.res_err   = err_q;
    bus.res_sum   = err_q ? '0 : stat_sum;
    bus.res_min   = err_q ? '0 : stat_min;
    bus.res_max   = err_q ? '0 : stat_max;
  end

  t_clkq_delta_stats #(
    .CNT_WIDTH(CNT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_stats (
    .clk    (clk),
    .rst    (rst),
    .clr    (st_clr),
    .cap0   (st_cap0),
    .cap1   (st_cap1),
    .upd    (st_upd),
    .cnt_in (meas_cnt),
    .sum    (stat_sum),
    .min_val(stat_min),
    .max_val(stat_max)
  );

endmodule
